// File: rtl/mem_stage.sv
// Memory-access stage: retires ALU results directly or runs a dmem load/store
// handshake, presenting a registered writeback bundle to the register file.
module mem_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        is_lw_i,
  input  logic        is_sw_i,
  input  logic        wb_req_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o
);

  // state   | meaning
  // IDLE    | ready to accept; non-memory ops retire from here
  // REQ     | dmem_req held until dmem_gnt
  // WAIT_RD | load granted, waiting for dmem_rvalid
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misaligned_q, misaligned_d;
  logic        ld_wb_req_q, ld_wb_req_d;

  logic accept;
  logic is_mem;

  assign in_ready_o = (state_q == IDLE);
  assign accept     = in_valid_i && in_ready_o;
  assign is_mem     = is_lw_i || is_sw_i;

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = wb_we_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misaligned_d = 1'b0;
    ld_wb_req_d  = ld_wb_req_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out_i;
            wb_rd_d    = rd_i;
            wb_we_d    = wb_req_i && (rd_i != 5'd0);
          end else if (alu_out_i[1:0] != 2'b00) begin
            wb_valid_d   = 1'b1;
            wb_we_d      = 1'b0;
            misaligned_d = 1'b1;
            wb_data_d    = alu_out_i;
            wb_rd_d      = rd_i;
          end else begin
            // a simultaneous lw+sw is treated as a store via is_sw alone
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_sw_i;
            dmem_addr_d  = alu_out_i;
            dmem_wdata_d = store_data_i;
            wb_rd_d      = rd_i;
            ld_wb_req_d  = wb_req_i;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            state_d    = IDLE;
          end else if (dmem_rvalid_i) begin
            wb_valid_d = 1'b1;
            wb_data_d  = dmem_rdata_i;
            wb_we_d    = ld_wb_req_q && (wb_rd_q != 5'd0);
            state_d    = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_data_d  = dmem_rdata_i;
          wb_we_d    = ld_wb_req_q && (wb_rd_q != 5'd0);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      misaligned_q <= 1'b0;
      ld_wb_req_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
      ld_wb_req_q  <= ld_wb_req_d;
    end
  end

  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_we_o      = wb_we_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, handshake corner sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, is_lw, is_sw, wb_req;
  logic [4:0]  rd;
  logic [31:0] alu_out, store_data;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        in_ready, dmem_req, dmem_we, wb_valid, wb_we, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_rd;

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .is_lw_i(is_lw), .is_sw_i(is_sw), .wb_req_i(wb_req), .rd_i(rd),
    .alu_out_i(alu_out), .store_data_i(store_data),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .misaligned_o(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; is_lw = 0; is_sw = 0; wb_req = 0; rd = 0;
    alu_out = 0; store_data = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic drive_op(input logic lw, input logic sw, input logic wr,
                          input logic [4:0] r, input logic [31:0] a, input logic [31:0] sd);
    in_valid = 1; is_lw = lw; is_sw = sw; wb_req = wr; rd = r; alu_out = a; store_data = sd;
  endtask

  task automatic do_reset();
    reset = 1;
    #12;
    reset = 0;
    step();
  endtask

  typedef struct {
    logic        v, lw, sw, wr;
    logic [4:0]  r;
    logic [31:0] a;
    logic        e_wbv, e_we, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[8];

  // transaction-level reference state
  bit          m_busy, m_granted, m_store, m_wr;
  logic        e_req, e_we, e_wbv, e_wbwe, e_mis;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [4:0]  e_rd;

  task automatic model_retire_load(input logic [31:0] data);
    e_wbv = 1; e_data = data; e_wbwe = m_wr && (e_rd != 0); m_busy = 0;
  endtask

  task automatic model_cycle();
    e_wbv = 0; e_mis = 0;
    if (!m_busy) begin
      if (in_valid) begin
        if (!(is_lw || is_sw)) begin
          e_wbv = 1; e_data = alu_out; e_rd = rd; e_wbwe = wb_req && (rd != 0);
        end else if (alu_out % 4 != 0) begin
          e_wbv = 1; e_mis = 1; e_wbwe = 0; e_data = alu_out; e_rd = rd;
        end else begin
          m_busy = 1; m_granted = 0; m_store = is_sw; m_wr = wb_req;
          e_req = 1; e_we = is_sw; e_addr = alu_out; e_wdata = store_data; e_rd = rd;
        end
      end
    end else if (!m_granted) begin
      if (dmem_gnt) begin
        e_req = 0;
        if (m_store) begin
          e_wbv = 1; e_wbwe = 0; m_busy = 0;
        end else if (dmem_rvalid) begin
          model_retire_load(dmem_rdata);
        end else begin
          m_granted = 1;
        end
      end
    end else if (dmem_rvalid) begin
      model_retire_load(dmem_rdata);
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 1, 5'd5, 32'h10,       1, 1, 0, 5'd5, 32'h10};
    vecs[1] = '{1, 0, 0, 1, 5'd0, 32'h30,       1, 0, 0, 5'd0, 32'h30};
    vecs[2] = '{1, 0, 0, 0, 5'd3, 32'hABCD,     1, 0, 0, 5'd3, 32'hABCD};
    vecs[3] = '{1, 1, 0, 1, 5'd4, 32'h201,      1, 0, 1, 5'd4, 32'h201};
    vecs[4] = '{1, 0, 1, 0, 5'd6, 32'h102,      1, 0, 1, 5'd6, 32'h102};
    vecs[5] = '{1, 1, 1, 1, 5'd8, 32'h3,        1, 0, 1, 5'd8, 32'h3};
    vecs[6] = '{0, 0, 0, 1, 5'd9, 32'h40,       0, 0, 0, 5'd0, 32'h0};
    vecs[7] = '{1, 1, 0, 0, 5'd31, 32'hFFFFFFFF, 1, 0, 1, 5'd31, 32'hFFFFFFFF};

    idle_inputs();
    reset = 1;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    #9 reset = 0;
    step();

    // directed vector table, single-cycle ops from IDLE
    for (int i = 0; i < 8; i++) begin
      drive_op(vecs[i].lw, vecs[i].sw, vecs[i].wr, vecs[i].r, vecs[i].a, 32'h5555);
      in_valid = vecs[i].v;
      chk("vec_in_ready", in_ready, 1);
      step();
      chk("vec_wb_valid", wb_valid, vecs[i].e_wbv);
      chk("vec_misaligned", misaligned, vecs[i].e_mis);
      chk("vec_dmem_req", dmem_req, 0);
      if (vecs[i].e_wbv) begin
        chk("vec_wb_we", wb_we, vecs[i].e_we);
        chk("vec_wb_rd", wb_rd, vecs[i].e_rd);
        chk("vec_wb_data", wb_data, vecs[i].e_data);
      end
    end
    idle_inputs();
    step();

    // arithmetic stream rd=5,6,0
    drive_op(0, 0, 1, 5'd5, 32'h10, 0); step();
    chk("arith0_valid", wb_valid, 1); chk("arith0_we", wb_we, 1); chk("arith0_ready", in_ready, 1);
    drive_op(0, 0, 1, 5'd6, 32'h20, 0); step();
    chk("arith1_valid", wb_valid, 1); chk("arith1_we", wb_we, 1); chk("arith1_data", wb_data, 32'h20);
    drive_op(0, 0, 1, 5'd0, 32'h30, 0); step();
    chk("arith2_valid", wb_valid, 1); chk("arith2_we", wb_we, 0); chk("arith2_ready", in_ready, 1);
    idle_inputs(); step();
    chk("arith_done_valid", wb_valid, 0);

    // store with two-cycle grant delay
    drive_op(0, 1, 0, 5'd2, 32'h100, 32'hDEADBEEF); step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk("st_req", dmem_req, 1); chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 32'h100); chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("st_ready", in_ready, 0); chk("st_wbv", wb_valid, 0);
      if (c == 2) dmem_gnt = 1;
      if (c < 2) step();
    end
    step();
    dmem_gnt = 0;
    chk("st_req_drop", dmem_req, 0); chk("st_wbv", wb_valid, 1);
    chk("st_wbwe", wb_we, 0); chk("st_ready_back", in_ready, 1);

    // zero-wait load
    drive_op(1, 0, 1, 5'd7, 32'h200, 0); step();
    idle_inputs();
    chk("ld0_req", dmem_req, 1); chk("ld0_we", dmem_we, 0);
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h12345678; step();
    idle_inputs();
    chk("ld0_wbv", wb_valid, 1); chk("ld0_wbwe", wb_we, 1);
    chk("ld0_rd", wb_rd, 7); chk("ld0_data", wb_data, 32'h12345678);
    chk("ld0_req_drop", dmem_req, 0);

    // load with latency: grant N+1, rvalid N+4, retire N+5
    drive_op(1, 0, 1, 5'd12, 32'h300, 0); step();
    idle_inputs();
    chk("ldl_ready_n1", in_ready, 0);
    dmem_gnt = 1; step();
    dmem_gnt = 0;
    chk("ldl_req_drop", dmem_req, 0); chk("ldl_ready_n2", in_ready, 0);
    step();
    chk("ldl_ready_n3", in_ready, 0);
    step();
    chk("ldl_ready_n4", in_ready, 0); chk("ldl_wbv_n4", wb_valid, 0);
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D; step();
    chk("ldl_wbv", wb_valid, 1); chk("ldl_data", wb_data, 32'hCAFEF00D);
    chk("ldl_rd", wb_rd, 12); chk("ldl_ready_n5", in_ready, 1);
    dmem_rdata = 32'h0BADBAD0; step();
    dmem_rvalid = 0;
    chk("spur_wbv", wb_valid, 0); chk("spur_data", wb_data, 32'hCAFEF00D);

    // misaligned load
    drive_op(1, 0, 1, 5'd9, 32'h203, 0); step();
    idle_inputs();
    chk("mis_req", dmem_req, 0); chk("mis_wbv", wb_valid, 1);
    chk("mis_flag", misaligned, 1); chk("mis_we", wb_we, 0);
    chk("mis_data", wb_data, 32'h203);
    step();
    chk("mis_pulse", misaligned, 0);

    // async reset mid-access
    drive_op(1, 0, 1, 5'd3, 32'h400, 0); step();
    idle_inputs();
    chk("rsta_req_before", dmem_req, 1);
    #2 reset = 1;
    #1;
    chk("rsta_req", dmem_req, 0); chk("rsta_wbv", wb_valid, 0); chk("rsta_ready", in_ready, 1);
    #3 reset = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h77;
    step();
    dmem_rvalid = 0;
    chk("rsta_late_rvalid", wb_valid, 0); chk("rsta_req_after", dmem_req, 0);

    // randomized run against reference model
    idle_inputs();
    do_reset();
    m_busy = 0; m_granted = 0; m_store = 0; m_wr = 0;
    e_req = 0; e_we = 0; e_wbv = 0; e_wbwe = 0; e_mis = 0;
    e_addr = 0; e_wdata = 0; e_data = 0; e_rd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      a = $urandom();
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      in_valid = ($urandom_range(0, 3) != 0);
      is_lw = (k >= 5 && k <= 6) || k == 9;
      is_sw = (k >= 7);
      wb_req = ($urandom_range(0, 4) != 0);
      rd = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
      alu_out = a;
      store_data = $urandom();
      dmem_gnt = ($urandom_range(0, 2) == 0);
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom();
      chk("rnd_in_ready", in_ready, m_busy ? 0 : 1);
      model_cycle();
      step();
      chk("rnd_dmem_req", dmem_req, e_req);
      chk("rnd_wb_valid", wb_valid, e_wbv);
      chk("rnd_misaligned", misaligned, e_mis);
      chk("rnd_wb_rd", wb_rd, e_rd);
      chk("rnd_wb_data", wb_data, e_data);
      chk("rnd_wb_we", wb_we, e_wbwe);
      if (e_req) begin
        chk("rnd_dmem_we", dmem_we, e_we);
        chk("rnd_dmem_addr", dmem_addr, e_addr);
        chk("rnd_dmem_wdata", dmem_wdata, e_wdata);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
